// File: rtl/axi_pkg.sv
// axi_pkg: AXI4 read-channel encodings, requester IDs and arbiter FSM states
// shared by the read arbiter and its round-robin grant.
package axi_pkg;
    localparam logic [2:0] SIZE_4B    = 3'd2;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [2:0] PROT_INSTR = 3'b100;
    localparam logic [2:0] PROT_DATA  = 3'b000;
    localparam logic [3:0] ID_INSTR   = 4'd0;
    localparam logic [3:0] ID_DATA    = 4'd1;

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_RESP} state_e;

    // owner bit: 0 = IFU, 1 = LSU
    function automatic logic [3:0] id_of(input logic owner);
        return owner ? ID_DATA : ID_INSTR;
    endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant; on a tie the requester that was not
// served last wins. last_owner resets to LSU so IFU wins the first tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    input  logic       owner_i,
    output logic [1:0] gnt_o
);
    logic last_q, last_d;

    assign last_d   = upd_i ? owner_i : last_q;
    assign gnt_o[0] = req_i[0] && (!req_i[1] || last_q);
    assign gnt_o[1] = req_i[1] && (!req_i[0] || !last_q);

    always_ff @(posedge clk) begin
        last_q <= !rstn ? 1'b1 : last_d;
    end
endmodule

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI4 read master between IFU and LSU, one
// outstanding single-beat transaction at a time, response routed by RID.
module axi_rd_arbiter
    import axi_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_req_ready,
    output logic              if_resp_valid,
    output logic [DATA_W-1:0] if_resp_data,
    output logic              if_resp_err,
    input  logic              ls_req_valid,
    input  logic [ADDR_W-1:0] ls_req_addr,
    input  logic [2:0]        ls_req_size,
    output logic              ls_req_ready,
    output logic              ls_resp_valid,
    output logic [DATA_W-1:0] ls_resp_data,
    output logic              ls_resp_err,
    output logic [3:0]        ARID,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [7:0]        ARLEN,
    output logic [2:0]        ARSIZE,
    output logic [1:0]        ARBURST,
    output logic [2:0]        ARPROT,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [3:0]        RID,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RLAST,
    input  logic              RVALID,
    output logic              RREADY
);
    localparam int CNT_W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic [3:0]        arid_q, arid_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [2:0]        arsize_q, arsize_d, arprot_q, arprot_d;
    logic              arvalid_q, arvalid_d, rready_q, rready_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              if_rv_q, if_rv_d, ls_rv_q, ls_rv_d;
    logic              if_err_q, if_err_d, ls_err_q, ls_err_d;
    logic [DATA_W-1:0] if_rd_q, if_rd_d, ls_rd_q, ls_rd_d, rsp_data;
    logic [1:0]        gnt;
    logic              win, hit, tmo, done, rsp_err;

    rr_arb2 u_arb (
        .clk    (clk),
        .rstn   (rstn),
        .req_i  ({ls_req_valid, if_req_valid} & {2{state_q == ST_IDLE}}),
        .upd_i  (done),
        .owner_i(owner_q),
        .gnt_o  (gnt)
    );

    assign win  = gnt[1];
    assign hit  = state_q == ST_RESP && RVALID && RLAST && RID == id_of(owner_q);
    // the counter value TIMEOUT-1 means TIMEOUT is reached on this edge
    assign tmo  = TIMEOUT != 0 && state_q == ST_RESP && 32'(cnt_q) == 32'(TIMEOUT - 1);
    assign done = hit || tmo;
    assign rsp_data = hit ? RDATA : '0;
    assign rsp_err  = hit ? RRESP != RESP_OKAY : 1'b1;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        arid_d    = arid_q;
        araddr_d  = araddr_q;
        arsize_d  = arsize_q;
        arprot_d  = arprot_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        cnt_d     = cnt_q;
        if_rv_d   = done && !owner_q;
        ls_rv_d   = done && owner_q;
        if_rd_d   = if_rv_d ? rsp_data : if_rd_q;
        ls_rd_d   = ls_rv_d ? rsp_data : ls_rd_q;
        if_err_d  = if_rv_d ? rsp_err : if_err_q;
        ls_err_d  = ls_rv_d ? rsp_err : ls_err_q;
        case (state_q)
            ST_IDLE: if (|gnt) begin
                owner_d   = win;
                arid_d    = id_of(win);
                araddr_d  = win ? ls_req_addr : if_req_addr;
                arsize_d  = win ? ls_req_size : SIZE_4B;
                arprot_d  = win ? PROT_DATA : PROT_INSTR;
                arvalid_d = 1'b1;
                state_d   = ST_ADDR;
            end
            ST_ADDR: if (ARREADY) begin
                arvalid_d = 1'b0;
                rready_d  = 1'b1;
                cnt_d     = '0;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                cnt_d = cnt_q + 1'b1;
                if (done) begin
                    rready_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b0;
            arid_q    <= '0;
            araddr_q  <= '0;
            arsize_q  <= '0;
            arprot_q  <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            cnt_q     <= '0;
            if_rv_q   <= 1'b0;
            ls_rv_q   <= 1'b0;
            if_err_q  <= 1'b0;
            ls_err_q  <= 1'b0;
            if_rd_q   <= '0;
            ls_rd_q   <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            arid_q    <= arid_d;
            araddr_q  <= araddr_d;
            arsize_q  <= arsize_d;
            arprot_q  <= arprot_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            cnt_q     <= cnt_d;
            if_rv_q   <= if_rv_d;
            ls_rv_q   <= ls_rv_d;
            if_err_q  <= if_err_d;
            ls_err_q  <= ls_err_d;
            if_rd_q   <= if_rd_d;
            ls_rd_q   <= ls_rd_d;
        end
    end

    assign if_req_ready  = gnt[0];
    assign ls_req_ready  = gnt[1];
    assign if_resp_valid = if_rv_q;
    assign if_resp_data  = if_rd_q;
    assign if_resp_err   = if_err_q;
    assign ls_resp_valid = ls_rv_q;
    assign ls_resp_data  = ls_rd_q;
    assign ls_resp_err   = ls_err_q;
    assign ARID    = arid_q;
    assign ARADDR  = araddr_q;
    assign ARLEN   = 8'd0;
    assign ARSIZE  = arsize_q;
    assign ARBURST = BURST_INCR;
    assign ARPROT  = arprot_q;
    assign ARVALID = arvalid_q;
    assign RREADY  = rready_q;
endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares the single AXI4 read master port (AR/R channels) between the instruction-fetch requester (IFU) and the load requester (LSU).
- Each requester uses a simple valid/ready request interface and receives a one-cycle response pulse.
- The block arbitrates round-robin, drives one outstanding AR transaction at a time, and routes the R beat back to the owner by RID.
- It sits between the pipeline front/mem stages and the AXI interconnect.

Parameters:
- ADDR_W, 64, address width of requests and ARADDR.
- DATA_W, 64, width of RDATA and response data.
- TIMEOUT, 1023, maximum cycles waited in RESP before a forced error response; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; rstn, synchronous, active-low; clock clk.
- if_req_valid  in  1  IFU read request.
- if_req_addr  in  ADDR_W  IFU address.
- if_req_ready  out  1  IFU request accepted this cycle when high together with valid.
- if_resp_valid  out  1  one-cycle pulse, IFU data returned.
- if_resp_data  out  DATA_W  IFU returned data (RDATA).
- if_resp_err  out  1  IFU error qualifier, valid with if_resp_valid.
- ls_req_valid  in  1  LSU read request.
- ls_req_addr  in  ADDR_W  LSU address.
- ls_req_size  in  3  LSU AxSIZE encoding.
- ls_req_ready  out  1  LSU request accepted.
- ls_resp_valid  out  1  one-cycle pulse, LSU data returned.
- ls_resp_data  out  DATA_W  LSU returned data.
- ls_resp_err  out  1  LSU error qualifier.
- ARID  out  4  0 for IFU, 1 for LSU.
- ARADDR  out  ADDR_W  read address.
- ARLEN  out  8  always 0 (single beat).
- ARSIZE  out  3  2 (4 bytes) for IFU; ls_req_size for LSU.
- ARBURST  out  2  always 2'b01 (INCR).
- ARPROT  out  3  3'b100 for IFU, 3'b000 for LSU.
- ARVALID  out  1  address valid.
- ARREADY  in  1  address accepted.
- RID  in  4  response ID.
- RDATA  in  DATA_W  response data.
- RRESP  in  2  response status.
- RLAST  in  1  last beat.
- RVALID  in  1  response valid.
- RREADY  out  1  response ready.

Behaviour:
- Reset (rstn=0 at posedge clk):
  - state=IDLE, last_owner=LSU, so IFU wins the first tie.
  - All AR outputs, ARVALID, RREADY, all resp_valid/resp_err and the timeout counter are 0.
  - Any in-flight transaction is abandoned; no response is issued for it.
- FSM states: IDLE, ADDR, RESP.
- IDLE:
  - Grant is combinational. If only one requester is valid, it wins. If both are valid, the requester that is not last_owner wins.
  - req_ready=1 only for the granted requester and only in IDLE. Both req_ready are 0 in ADDR and RESP.
  - On handshake, register ARID/ARADDR/ARSIZE/ARPROT for the winner, set ARVALID<=1, owner<=winner, and go to ADDR.
  - Latency: request accept to ARVALID high is 1 cycle.
- ADDR:
  - ARVALID and all AR fields are held stable until ARREADY.
  - On ARVALID&&ARREADY: ARVALID<=0, RREADY<=1, clear the timeout counter, go to RESP.
- RESP:
  - RREADY=1.
  - Matching beat is RVALID && RLAST && RID==ID(owner). On it:
    - the owner's resp_valid pulses 1 cycle later (registered);
    - resp_data<=RDATA;
    - resp_err<=(RRESP!=2'b00);
    - RREADY<=0, last_owner<=owner, go to IDLE.
  - A beat with a non-matching RID or RLAST=0 is consumed and dropped; the block stays in RESP and the counter keeps running.
  - Timeout: when TIMEOUT!=0 and the counter reaches TIMEOUT, the owner's resp_valid=1 with resp_err=1 and resp_data=0, and the block goes to IDLE. Late beats arriving in IDLE are not accepted (RREADY=0).
- Back-to-back: a new request can be accepted the cycle after returning to IDLE. Minimum turnaround, request-accept to resp_valid with ARREADY/RVALID immediate, is 3 cycles.
- Response outputs are valid only while resp_valid=1. resp_data holds its last value otherwise.
- The non-owner's resp_valid is never asserted.
- Requesters must hold req_valid/addr stable until ready. The block does not check this.

Decomposition:
- Shared package axi_pkg holds:
  - AxSIZE/AxBURST/xRESP/AxPROT localparams;
  - ID_INSTR=4'd0, ID_DATA=4'd1;
  - FSM state encodings.
- One natural sub-module, rr_arb2: a 2-input round-robin grant with a last_owner register and an update enable. The rest stays flat.

Test Plan:
- IFU only, addr 0x8000_0000, ARREADY same cycle, RDATA=0x0000_0000_0010_0093 with RID=0 RRESP=0 RLAST=1 one cycle later:
  - ARID=0, ARSIZE=2, ARPROT=4;
  - if_resp_valid 1 cycle, data 0x...0093, err=0;
  - ls_resp_valid never asserted.
- Both requesters valid continuously for 4 transactions:
  - grants alternate IFU, LSU, IFU, LSU;
  - ARID sequence 0, 1, 0, 1.
- LSU addr 0x8000_1008, size 3, ARREADY held 0 for 5 cycles:
  - ARVALID and ARADDR stay stable for all 5 cycles;
  - both req_ready stay 0 until the response returns.
- LSU in flight, R beat with RID=0 arrives first, then RID=1 with RRESP=2'b10:
  - the first beat is dropped;
  - ls_resp_valid pulses with err=1.
- TIMEOUT=8, IFU request, no RVALID:
  - if_resp_valid with err=1 exactly 8 cycles after entering RESP;
  - the next request is then accepted normally.
- rstn deasserted low during RESP:
  - the next cycle shows ARVALID=0, RREADY=0, no resp_valid;
  - after reset, IFU wins the first tie.
